// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexed driver for the stopwatch's 4-digit 7-segment display.
//   One digit is lit per scan slot. The first cycle of every slot is a dead
//   cycle with all anodes off, which stops the previous digit ghosting into
//   the next one. While ADJ=1 the digit chosen by SEL blinks.
//
// Ports
//   clk_c     in   1  system clock
//   reset_c   in   1  asynchronous active-low reset
//   sec_ones  in   4  BCD seconds units
//   sec_tens  in   4  BCD seconds tens
//   min_ones  in   4  BCD minutes units
//   min_tens  in   4  BCD minutes tens
//   ADJ       in   1  adjust mode, enables blinking
//   SEL       in   2  digit under adjust (0 sec_ones .. 3 min_tens)
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point / colon, active-low
//   an        out  4  digit anodes, active-low; an[0]=sec_ones .. an[3]=min_tens
module seg_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  // Colon sits between minutes and seconds, i.e. on the min_ones digit.
  localparam logic [1:0] COLON_IDX = 2'd2;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  logic [SCAN_W-1:0]  scan_cnt_nxt;
  logic [1:0]         idx_nxt;
  logic [BLINK_W-1:0] blink_cnt_nxt;
  logic               phase_nxt;
  logic [3:0]         an_nxt;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;

  logic [3:0]         digit;
  logic               dead;
  logic               blanked;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Digits are not latched: the currently selected input feeds the decoder.
  always_comb begin
    digit = sec_ones;
    case (idx)
      2'd0: digit = sec_ones;
      2'd1: digit = sec_tens;
      2'd2: digit = min_ones;
      2'd3: digit = min_tens;
      default: digit = sec_ones;
    endcase
  end

  assign dead    = (scan_cnt == '0);
  assign blanked = ADJ && phase && (idx == SEL);

  always_comb begin
    scan_cnt_nxt = scan_cnt + 1'b1;
    idx_nxt      = idx;
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_nxt = '0;
      idx_nxt      = idx + 2'd1;
    end
  end

  // Blink timer only runs in adjust mode; leaving adjust clears it so that
  // re-entering always starts with the digit visible.
  always_comb begin
    blink_cnt_nxt = '0;
    phase_nxt     = 1'b0;
    if (ADJ) begin
      blink_cnt_nxt = blink_cnt + 1'b1;
      phase_nxt     = phase;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end
    end
  end

  always_comb begin
    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = decode(digit);
    dp_nxt  = (idx == COLON_IDX) ? 1'b0 : 1'b1;
    if (dead || blanked) begin
      an_nxt = AN_OFF;
    end
    if (dead) begin
      dp_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_c or negedge reset_c) begin
    if (!reset_c) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

  localparam int SD = 4;
  localparam int BD = 8;

  logic       clk_c = 1'b0;
  logic       reset_c;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       ADJ;
  logic [1:0] SEL;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;

  // Reference state: edges since reset release, and consecutive edges with ADJ=1.
  int n = 0;
  int k = 0;

  logic [6:0] seg_tab [16];
  logic [3:0] t1_an   [8];

  seg_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_c    (clk_c),
    .reset_c  (reset_c),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .ADJ      (ADJ),
    .SEL      (SEL),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk_c = ~clk_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict outputs from the pre-edge situation, clock once, compare.
  task automatic step();
    int         scan, idx, ph;
    logic [3:0] dig, e_an;
    logic [6:0] e_seg;
    logic       e_dp, adj_pre;
    scan    = n % SD;
    idx     = (n / SD) % 4;
    ph      = (k / BD) % 2;
    adj_pre = ADJ;
    case (idx)
      0: dig = sec_ones;
      1: dig = sec_tens;
      2: dig = min_ones;
      default: dig = min_tens;
    endcase
    e_seg = seg_tab[dig];
    if (scan == 0 || (ADJ && ph == 1 && idx == int'(SEL))) e_an = 4'b1111;
    else begin
      e_an = 4'b0001 << idx;
      e_an = ~e_an;
    end
    e_dp = (scan != 0 && idx == 2) ? 1'b0 : 1'b1;
    @(posedge clk_c);
    n++;
    k = adj_pre ? k + 1 : 0;
    #1;
    check("an",  32'(an),  32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp",  32'(dp),  32'(e_dp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},  32'(an),  32'h F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"},  32'(dp),  32'h1);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    t1_an   = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
                4'b1111, 4'b1101, 4'b1101, 4'b1101};

    reset_c  = 1'b0;
    sec_ones = 4'd1; sec_tens = 4'd2; min_ones = 4'd3; min_tens = 4'd4;
    ADJ      = 1'b0;
    SEL      = 2'd0;
    #12;
    check_reset_vals("rst");
    @(posedge clk_c); #1;
    check_reset_vals("rst_hold");
    reset_c = 1'b1;
    n = 0; k = 0;

    // Basic scan with digits 1,2,3,4 and a literal anode pattern check.
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_an", 32'(an), 32'(t1_an[i]));
      if (i >= 1 && i <= 3) check("t1_seg", 32'(seg), 32'h79);
      if (i >= 5)           check("t1_seg", 32'(seg), 32'h24);
    end
    // Finish the rotation and wrap back to idx 0.
    for (int i = 0; i < 12; i++) step();

    // Invalid BCD on sec_tens blanks segments but keeps the anode active.
    sec_tens = 4'hC;
    for (int i = 0; i < 16; i++) step();
    sec_tens = 4'd2;

    // Blink min_ones, then leave adjust while phase is 1.
    SEL = 2'd2;
    ADJ = 1'b1;
    for (int i = 0; i < 12; i++) step();
    ADJ = 1'b0;
    for (int i = 0; i < 8; i++) step();
    ADJ = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // Asynchronous reset mid-slot.
    #2;
    reset_c = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk_c); #1;
    check_reset_vals("async_hold");
    #2;
    reset_c = 1'b1;
    n = 0; k = 0;
    @(negedge clk_c);
    for (int i = 0; i < 8; i++) step();

    // Randomized phase: digits, ADJ and SEL change at random between edges.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: sec_ones = 4'($urandom_range(0, 15));
          1: sec_tens = 4'($urandom_range(0, 15));
          2: min_ones = 4'($urandom_range(0, 15));
          default: min_tens = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 39) == 0) ADJ = ~ADJ;
      if ($urandom_range(0, 19) == 0) SEL = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset_c = 1'b0;
        #1;
        check_reset_vals("rand_rst");
        #1;
        reset_c = 1'b1;
        n = 0; k = 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
